lut_neuron_loader: RTL

LUT_NEURON_LOADER -- requirements
Module: lut_neuron_loader

---
 rtl/lut_loader_pkg.sv | 31 +++
 rtl/lut_table_ram.sv | 46 ++++
 rtl/lut_neuron_loader.sv | 115 +++++++++++
 3 files changed

// File: rtl/lut_loader_pkg.sv
// Shared types and derived sizing for the LUT neuron table loader.
package lut_loader_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      LOAD  = 2'd1,
      READY = 2'd2
   } state_t;

   // Sizing helpers so any parameterisation derives the same constants.
   function automatic int depth_of(input int in_bits);
      return 1 << in_bits;
   endfunction

   function automatic int e_of(input int out_bits, input int cfg_w);
      return cfg_w / out_bits;
   endfunction

   function automatic int beats_of(input int in_bits, input int out_bits, input int cfg_w);
      return ((1 << in_bits) * out_bits) / cfg_w;
   endfunction

   // Constants for the default build (8-bit code, 1-bit entries, 16-bit beats).
   localparam int IN_BITS_DEF  = 8;
   localparam int OUT_BITS_DEF = 1;
   localparam int CFG_W_DEF    = 16;
   localparam int DEPTH        = depth_of(IN_BITS_DEF);
   localparam int E            = e_of(OUT_BITS_DEF, CFG_W_DEF);
   localparam int BEATS        = beats_of(IN_BITS_DEF, OUT_BITS_DEF, CFG_W_DEF);

endpackage

// File: rtl/lut_table_ram.sv
// Table storage: one write port of E entries per beat, one registered read port.
module lut_table_ram
   import lut_loader_pkg::*;
#(
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 1,
   parameter int CFG_W    = 16,
   parameter int WADDR_W  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [WADDR_W-1:0]  waddr,
   input  logic [CFG_W-1:0]    wdata,
   input  logic                re,
   input  logic [IN_BITS-1:0]  raddr,
   output logic [OUT_BITS-1:0] rdata
);

   localparam int DEPTH_N = depth_of(IN_BITS);
   localparam int E_N     = e_of(OUT_BITS, CFG_W);

   // Entries packed flat: entry n occupies bits [n*OUT_BITS +: OUT_BITS].
   (* rom_style = "distributed" *) logic [DEPTH_N*OUT_BITS-1:0] mem;

   // Beat waddr fills entries waddr*E .. waddr*E+E-1; reset wipes the whole image.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem <= '0;
      end else if (we) begin
         for (int g = 0; g < DEPTH_N; g++) begin
            if (waddr == WADDR_W'(g / E_N))
               mem[g*OUT_BITS +: OUT_BITS] <= wdata[(g % E_N)*OUT_BITS +: OUT_BITS];
         end
      end
   end

   // Registered read; holds its last value when no lookup is issued.
   always_ff @(posedge clk) begin
      if (rst)
         rdata <= '0;
      else if (re)
         rdata <= mem[raddr*OUT_BITS +: OUT_BITS];
   end

endmodule

// File: rtl/lut_neuron_loader.sv
// LUT neuron: streams a truth table in as config beats, then serves one-cycle lookups.
module lut_neuron_loader
   import lut_loader_pkg::*;
#(
   parameter int IN_BITS  = 8,
   parameter int OUT_BITS = 1,
   parameter int CFG_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_start,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CFG_W-1:0]    cfg_data,
   output logic                cfg_done,
   output logic                loaded,
   input  logic                in_valid,
   input  logic [IN_BITS-1:0]  in_data,
   output logic                out_valid,
   output logic [OUT_BITS-1:0] out_data
);

   localparam int NUM_BEATS = beats_of(IN_BITS, OUT_BITS, CFG_W);
   localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             wr_en;
   logic             rd_en;
   logic             vld_p1;

   // cfg_ready mirrors the LOAD state; a restart cycle never accepts its beat.
   assign wr_en = cfg_ready && cfg_valid && !cfg_start;
   // A lookup issued while loaded completes even if a reload starts in the same cycle.
   assign rd_en = in_valid && loaded;

   // Load sequencer with registered handshake and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         cnt       <= '0;
         cfg_ready <= 1'b0;
         cfg_done  <= 1'b0;
         loaded    <= 1'b0;
      end else begin
         cfg_done <= 1'b0;
         case (state)
            EMPTY: begin
               if (cfg_start) begin
                  state     <= LOAD;
                  cnt       <= '0;
                  cfg_ready <= 1'b1;
               end
            end
            LOAD: begin
               if (cfg_start) begin
                  cnt <= '0;
               end else if (cfg_valid) begin
                  if (cnt == LAST_BEAT) begin
                     cnt       <= '0;
                     state     <= READY;
                     cfg_ready <= 1'b0;
                     cfg_done  <= 1'b1;
                     loaded    <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            READY: begin
               if (cfg_start) begin
                  state     <= LOAD;
                  cnt       <= '0;
                  cfg_ready <= 1'b1;
                  loaded    <= 1'b0;
               end
            end
            default: begin
               state     <= EMPTY;
               cnt       <= '0;
               cfg_ready <= 1'b0;
               loaded    <= 1'b0;
            end
         endcase
      end
   end

   // ---- stage p0 -> p1: lookup valid tracks the registered table read ----
   always_ff @(posedge clk) begin
      if (rst)
         vld_p1 <= 1'b0;
      else
         vld_p1 <= rd_en;
   end

   assign out_valid = vld_p1;

   lut_table_ram #(
      .IN_BITS  (IN_BITS),
      .OUT_BITS (OUT_BITS),
      .CFG_W    (CFG_W),
      .WADDR_W  (CNT_W)
   ) u_table (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_en),
      .waddr (cnt),
      .wdata (cfg_data),
      .re    (rd_en),
      .raddr (in_data),
      .rdata (out_data)
   );

endmodule
